// File: rtl/data_mem_io.sv
// data_mem_io: CPU data memory plus memory-mapped board I/O.
//   0x0xxx_xxxx : word RAM, 2^RAM_AW words, addresses alias above bit RAM_AW+1
//   0xCxxx_xxxx : I/O registers, offset addr[7:2]
//   anything else: unmapped (reads 0, writes dropped)
// Build option: define DMEM_TIMER_EN to include the compare timer (TCMP/TSTAT).
// Loads are combinational and return the pre-store value in a store cycle.
module data_mem_io #(
  parameter int RAM_AW = 10
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wmem,
  output logic [31:0] rdata,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [9:0]  led,
  output logic [31:0] hex,
  output logic        timer_irq
);

  localparam logic [5:0] OFF_SW    = 6'h00;
  localparam logic [5:0] OFF_KEY   = 6'h01;
  localparam logic [5:0] OFF_LED   = 6'h02;
  localparam logic [5:0] OFF_HEX   = 6'h03;
  localparam logic [5:0] OFF_CYCLE = 6'h04;
  localparam logic [5:0] OFF_TCMP  = 6'h05;
  localparam logic [5:0] OFF_TSTAT = 6'h06;

  // Address decode
  logic              sel_ram;
  logic              sel_io;
  logic [5:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              io_we;
  logic              unused_addr;

  assign sel_ram     = (addr[31:28] == 4'h0);
  assign sel_io      = (addr[31:28] == 4'hC);
  assign io_off      = addr[7:2];
  assign ram_idx     = addr[RAM_AW+1:2];
  assign ram_we      = wmem & sel_ram;
  assign io_we       = wmem & sel_io;
  // Bits outside the decoded fields are deliberately ignored.
  assign unused_addr = ^addr;

  // RAM array: no reset so contents survive resetn
  logic [31:0] mem_q [2**RAM_AW];

  // RAM write port; a store on an edge while resetn is low is dropped
  always_ff @(posedge clock) begin
    if (resetn && ram_we) begin
      mem_q[ram_idx] <= wdata;
    end
  end

  // Board I/O and cycle counter state
  logic [9:0]  sw_s1_q, sw_s2_q;
  logic [3:0]  key_s1_q, key_s2_q;
  logic [9:0]  led_q, led_d;
  logic [31:0] hex_q, hex_d;
  logic [31:0] cycle_q, cycle_d;

  // Next-state for LED/HEX stores and the free-running cycle counter
  always_comb begin
    led_d   = led_q;
    hex_d   = hex_q;
    cycle_d = cycle_q + 32'd1;
    if (io_we && io_off == OFF_LED) led_d = wdata[9:0];
    if (io_we && io_off == OFF_HEX) hex_d = wdata;
  end

  // I/O registers and two-flop input synchronizers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '0;
      key_s2_q <= '0;
      led_q    <= '0;
      hex_q    <= '0;
      cycle_q  <= '0;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
      led_q    <= led_d;
      hex_q    <= hex_d;
      cycle_q  <= cycle_d;
    end
  end

  assign led = led_q;
  assign hex = hex_q;

`ifdef DMEM_TIMER_EN
  logic [31:0] tcmp_q, tcmp_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        expired_q, expired_d;
  logic        timer_hit;

  // Timer: count reaching TCMP sets expired and restarts; set beats W1C
  always_comb begin
    tcmp_d    = tcmp_q;
    tcnt_d    = tcnt_q;
    expired_d = expired_q;
    timer_hit = (tcmp_q != 32'd0) && ((tcnt_q + 32'd1) == tcmp_q);
    if (tcmp_q == 32'd0) begin
      tcnt_d = '0;
    end else if (timer_hit) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 32'd1;
    end
    if (io_we && io_off == OFF_TCMP) begin
      tcmp_d = wdata;
      tcnt_d = '0;
    end
    if (io_we && io_off == OFF_TSTAT && wdata[0]) expired_d = 1'b0;
    if (timer_hit) expired_d = 1'b1;
  end

  // Timer state registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tcmp_q    <= '0;
      tcnt_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      tcmp_q    <= tcmp_d;
      tcnt_q    <= tcnt_d;
      expired_q <= expired_d;
    end
  end

  assign timer_irq = expired_q;
`else
  assign timer_irq = 1'b0;
`endif

  // Zero-latency load mux
  always_comb begin
    rdata = '0;
    if (sel_ram) begin
      rdata = mem_q[ram_idx];
    end else if (sel_io) begin
      case (io_off)
        OFF_SW:    rdata = {22'b0, sw_s2_q};
        OFF_KEY:   rdata = {28'b0, key_s2_q};
        OFF_LED:   rdata = {22'b0, led_q};
        OFF_HEX:   rdata = hex_q;
        OFF_CYCLE: rdata = cycle_q;
`ifdef DMEM_TIMER_EN
        OFF_TCMP:  rdata = tcmp_q;
        OFF_TSTAT: rdata = {31'b0, expired_q};
`else
        OFF_TCMP:  rdata = '0;
        OFF_TSTAT: rdata = '0;
`endif
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// tb_data_mem_io: directed test of data_mem_io (RAM, I/O map, timer, reset).
module tb_data_mem_io;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wmem;
  logic [31:0] rdata;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  led;
  logic [31:0] hex;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  // Reference cycle count: edges since the last reset release
  logic [31:0] ref_cycle;

  data_mem_io #(.RAM_AW(10)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .addr      (addr),
    .wdata     (wdata),
    .wmem      (wmem),
    .rdata     (rdata),
    .sw        (sw),
    .key       (key),
    .led       (led),
    .hex       (hex),
    .timer_irq (timer_irq)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle reference model
  always @(posedge clock or negedge resetn) begin
    if (!resetn) ref_cycle <= '0;
    else         ref_cycle <= ref_cycle + 32'd1;
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, land 1 ns after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wmem  = 1'b1;
    step();
    wmem  = 1'b0;
  endtask

  task automatic load_check(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    wmem = 1'b0;
    #1;
    check(rdata, exp, tag);
  endtask

  initial begin
    int waited;
    resetn = 1'b0;
    addr   = '0;
    wdata  = '0;
    wmem   = 1'b0;
    sw     = '0;
    key    = '0;
    #1;
    // Reset state
    check({22'b0, led}, 32'h0, "rst_led");
    check(hex, 32'h0, "rst_hex");
    check({31'b0, timer_irq}, 32'h0, "rst_irq");
    load_check(32'hC000_0010, 32'h0, "rst_cycle");
    step();
    step();
    load_check(32'hC000_0010, 32'h0, "rst_cycle_held");
    resetn = 1'b1;

    // RAM store/load and aliasing
    store(32'h0000_0010, 32'h1234_5678);
    load_check(32'h0000_0010, 32'h1234_5678, "ram_load");
    load_check(32'h0000_1010, 32'h1234_5678, "ram_alias");

    // Read during write returns old data
    store(32'h0000_0010, 32'h0000_000A);
    addr  = 32'h0000_0010;
    wdata = 32'h0000_000B;
    wmem  = 1'b1;
    #1;
    check(rdata, 32'h0000_000A, "rdw_old");
    step();
    wmem = 1'b0;
    #1;
    check(rdata, 32'h0000_000B, "rdw_new");

    // LED: narrow register
    store(32'hC000_0008, 32'hFFFF_FFFF);
    check({22'b0, led}, 32'h0000_03FF, "led_pins");
    load_check(32'hC000_0008, 32'h0000_03FF, "led_read");

    // HEX
    store(32'hC000_000C, 32'hDEAD_BEEF);
    check(hex, 32'hDEAD_BEEF, "hex_pins");
    load_check(32'hC000_000C, 32'hDEAD_BEEF, "hex_read");

    // SW synchronizer latency
    addr = 32'hC000_0000;
    sw   = 10'h155;
    #1;
    check(rdata, 32'h0, "sw_edge0");
    step();
    check(rdata, 32'h0, "sw_edge1");
    step();
    check(rdata, 32'h0000_0155, "sw_edge2");

    // KEY synchronizer
    addr = 32'hC000_0004;
    key  = 4'hA;
    step();
    check(rdata, 32'h0, "key_edge1");
    step();
    check(rdata, 32'h0000_000A, "key_edge2");

    // CYCLE counts and ignores writes
    load_check(32'hC000_0010, ref_cycle, "cycle_run");
    store(32'hC000_0010, 32'h0001_2345);
    load_check(32'hC000_0010, ref_cycle, "cycle_wr_ignored");

    // Unmapped I/O offset and unmapped region
    store(32'hC000_0040, 32'h5555_5555);
    load_check(32'hC000_0040, 32'h0, "io_unmapped");
    store(32'h8000_0000, 32'hFFFF_FFFF);
    load_check(32'h8000_0000, 32'h0, "unmapped_read");
    check({22'b0, led}, 32'h0000_03FF, "unmapped_led");
    check(hex, 32'hDEAD_BEEF, "unmapped_hex");
    load_check(32'h0000_0010, 32'h0000_000B, "unmapped_ram");

`ifdef DMEM_TIMER_EN
    // Timer: expiry 5 edges after TCMP write, set beats W1C
    store(32'hC000_0014, 32'd5);
    load_check(32'hC000_0014, 32'd5, "tcmp_read");
    repeat (4) step();
    check({31'b0, timer_irq}, 32'h0, "timer_pre");
    step();
    check({31'b0, timer_irq}, 32'h1, "timer_expire");
    load_check(32'hC000_0018, 32'h1, "tstat_read");
    repeat (4) step();
    store(32'hC000_0018, 32'h1);
    check({31'b0, timer_irq}, 32'h1, "timer_set_wins");
    store(32'hC000_0018, 32'h1);
    check({31'b0, timer_irq}, 32'h0, "timer_w1c");
    store(32'hC000_0014, 32'd0);
    repeat (12) step();
    check({31'b0, timer_irq}, 32'h0, "timer_stopped");
`else
    // Timer absent: TCMP/TSTAT read 0, irq tied low
    store(32'hC000_0014, 32'd5);
    load_check(32'hC000_0014, 32'h0, "tcmp_absent");
    repeat (8) step();
    load_check(32'hC000_0018, 32'h0, "tstat_absent");
    check({31'b0, timer_irq}, 32'h0, "irq_absent");
`endif

    // Reset mid-run once CYCLE passes 100
    waited = 0;
    while (ref_cycle < 32'd100 && waited < 200) begin
      step();
      waited++;
    end
    if (waited >= 200) check(ref_cycle, 32'd100, "cycle_wait_timeout");
    load_check(32'hC000_0010, ref_cycle, "cycle_before_rst");
    resetn = 1'b0;
    #1;
    check({22'b0, led}, 32'h0, "midrst_led");
    load_check(32'hC000_0010, 32'h0, "midrst_cycle");
    resetn = 1'b1;
    load_check(32'h0000_0010, 32'h0000_000B, "midrst_ram_kept");
    step();
    load_check(32'hC000_0010, 32'h1, "cycle_after_rst");

    // Store on an edge during reset is dropped
    store(32'h0000_0020, 32'h0000_1111);
    addr   = 32'h0000_0020;
    wdata  = 32'h0000_2222;
    wmem   = 1'b1;
    resetn = 1'b0;
    step();
    wmem   = 1'b0;
    resetn = 1'b1;
    load_check(32'h0000_0020, 32'h0000_1111, "store_in_rst_dropped");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 Parameter RAM_AW, default 10: RAM word-address width, giving 2^RAM_AW 32-bit words.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 addr  input  32  byte address from the CPU MEM stage (ALU result); addr[1:0] ignored.
REQ-005 wdata  input  32  store data from the CPU MEM stage.
REQ-006 wmem  input  1  store enable from the CPU MEM stage.
REQ-007 rdata  output  32  load data returned to the CPU.
REQ-008 sw  input  10  board switches, asynchronous to clock.
REQ-009 key  input  4  board push-buttons, asynchronous to clock.
REQ-010 led  output  10  LED register.
REQ-011 hex  output  32  seven-segment digit register, 4 bits per digit.
REQ-012 timer_irq  output  1  timer-expired flag.

Function
REQ-013 Address decode SHALL be: RAM when addr[31:28]==4'h0, word index addr[RAM_AW+1:2], upper bits ignored (aliasing); I/O when addr[31:28]==4'hC, offset addr[7:2]; all other addresses unmapped.
REQ-014 rdata SHALL be a combinational function of addr and current state, valid in the same cycle, with zero latency.
REQ-015 A store SHALL take effect at the rising edge where wmem==1; a same-cycle load of the same address SHALL return the pre-store value.
REQ-016 The I/O map SHALL be:
  - 0x00 SW: RO, {22'b0, sw_sync}.
  - 0x04 KEY: RO, {28'b0, key_sync}.
  - 0x08 LED: RW, 10 bits.
  - 0x0C HEX: RW, 32 bits.
  - 0x10 CYCLE: RO, free-running counter.
  - 0x14 TCMP: RW, 32 bits.
  - 0x18 TSTAT: bit0 expired, write-1-to-clear.
REQ-017 sw and key SHALL each pass through a 2-flop synchronizer, so a register read reflects a pin change 2 clock edges later.
REQ-018 CYCLE SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0; writes to it SHALL be ignored.
REQ-019 Loads from unmapped addresses or unmapped I/O offsets SHALL return 0, and stores to them SHALL be ignored.
REQ-020 Upper bits of a narrower register SHALL be ignored on write and read back as 0.
REQ-021 Timer: internal 32-bit tcnt increments each cycle while TCMP!=0; when tcnt==TCMP, expired SHALL set and tcnt SHALL return to 0 on the same edge.
REQ-022 A write to TCMP SHALL clear tcnt to 0; TCMP==0 SHALL stop the timer and hold tcnt at 0.
REQ-023 Simultaneous expiry and a W1C write to TSTAT SHALL leave expired set (set wins).
REQ-024 timer_irq SHALL equal the registered expired flag.

Reset
REQ-025 On resetn low, the block SHALL immediately set led=0, hex=0, CYCLE=0, TCMP=0, tcnt=0, expired=0, timer_irq=0, and both synchronizer stages=0.
REQ-026 RAM contents SHALL NOT be reset and SHALL be preserved across reset.
REQ-027 A store whose edge coincides with resetn low SHALL be dropped.
REQ-028 rdata SHALL reflect the reset register values while resetn is low.

Configuration
REQ-029 Macro DMEM_TIMER_EN defined: the timer of REQ-021..REQ-024 SHALL be present.
REQ-030 Macro DMEM_TIMER_EN undefined: TCMP and TSTAT SHALL read 0, writes to them SHALL be ignored, timer_irq SHALL be tied to 0, and no tcnt/TCMP flops SHALL exist.

Verification
REQ-031 Store RAM: store 0x12345678 to 0x00000010, then load 0x00000010 -> rdata=0x12345678; load 0x00001010 (alias, RAM_AW=10) -> rdata=0x12345678.
REQ-032 Read-during-write: RAM[4]=0xA; store 0xB to 0x10 and load 0x10 in the same cycle -> rdata=0xA that cycle and 0xB the next cycle.
REQ-033 I/O: store 0xFFFFFFFF to 0xC0000008 -> led=0x3FF and readback=0x000003FF; set sw=0x155 -> SW reads 0x155 from the 2nd edge on and 0 before it.
REQ-034 Timer (DMEM_TIMER_EN): store 5 to 0xC0000014 -> timer_irq rises 5 edges later; store 1 to 0xC0000018 on the expiry edge -> timer_irq stays 1; a later W1C -> 0.
REQ-035 Reset mid-run: after CYCLE reaches 100 and led=0x3FF, pulse resetn low between edges -> CYCLE=0, led=0, and RAM[4] unchanged.
REQ-036 Unmapped: store to 0x80000000, then load it -> rdata=0, with no other register changed.
